pixel_stream_feeder: RTL and testbench
======================================

PIXEL_STREAM_FEEDER -- requirements
Module: pixel_stream_feeder

Interface
REQ-001 Parameter FRAME_W, default 320, pixels per line.
REQ-002 Parameter FRAME_H, default 240, lines per frame.
REQ-003 Parameter STEP, default 4, subsample stride in both axes, power of two, 1..16.
REQ-004 Parameter ADDR_W, default 17, frame-buffer address width.
REQ-005 clk  in  1  single clock, same clock as the UART pipeline tx_clk; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a frame transfer.
REQ-008 rd_addr  out  ADDR_W  frame-buffer read address, row*FRAME_W+col.
REQ-009 rd_en  out  1  frame-buffer read strobe.
REQ-010 rd_data  in  24  {r,g,b}, valid exactly 1 cycle after rd_en.
REQ-011 wantData  in  1  consumer level request for the next pixel.
REQ-012 newData  out  1  one-cycle pulse: r/g/b/grey hold a fresh pixel.
REQ-013 r, g, b  out  8 each  pixel channels, held until the next newData.
REQ-014 grey  out  10  r+g+b, zero-extended, no truncation; max 765.
REQ-015 noMore  out  1  level: the frame is exhausted.
REQ-016 busy  out  1  high from the accepted start until DONE is entered.

Function
REQ-017 States: IDLE, ARMED, FETCH, WAIT, PRESENT, RELEASE, DONE.
REQ-018 IDLE -> ARMED on start; col and row cleared to 0; noMore cleared.
REQ-019 ARMED -> FETCH when wantData=1; otherwise stay in ARMED.
REQ-020 FETCH: rd_en=1 for exactly one cycle with rd_addr=row*FRAME_W+col; -> WAIT.
REQ-021 WAIT: capture rd_data into r/g/b and grey; -> PRESENT.
REQ-022 PRESENT: newData=1 for one cycle; advance col by STEP; if col+STEP>=FRAME_W, col=0 and row+=STEP; -> RELEASE.
REQ-023 RELEASE: wait for wantData=0 (four-phase handshake).
REQ-024 On leaving RELEASE: -> DONE if row>=FRAME_H, else -> ARMED.
REQ-025 Latency: wantData rising in ARMED to the newData pulse is exactly 3 cycles.
REQ-026 DONE: noMore=1 and busy=0; noMore stays high until the next start or reset.
REQ-027 DONE -> ARMED on start, with a fresh frame.
REQ-028 A start pulse outside IDLE/DONE is ignored.
REQ-029 wantData asserted while in DONE produces no newData.
REQ-030 Pixel count per frame is ceil(FRAME_W/STEP)*ceil(FRAME_H/STEP).
REQ-031 The last pixel sits at row=((FRAME_H-1)/STEP)*STEP, col=((FRAME_W-1)/STEP)*STEP.
REQ-032 rd_addr is computed with ADDR_W-wide arithmetic; the address is never wider than FRAME_W*FRAME_H-1.

Reset
REQ-033 Reset asserted, at any state including mid-handshake: state=IDLE, row=col=0.
REQ-034 Reset values: rd_en=0, rd_addr=0, newData=0, noMore=0, busy=0, r=g=b=0, grey=0.
REQ-035 After reset deasserts, no activity occurs until start.

Structure
REQ-036 The state enum, the {r,g,b} pixel struct and a GREY_W=10 constant live in the shared uart package.
REQ-037 One sub-module, subsample_counter, holds the col/row stride counters with wrap and a last flag.
REQ-038 The grey adder stays inline.

Verification
REQ-039 Reset mid-PRESENT -> next cycle all outputs are at reset values; a new start restarts at address 0.
REQ-040 FRAME_W=8, FRAME_H=4, STEP=2; start, then 8 four-phase requests -> rd_addr sequence 0,2,4,6,16,18,20,22; noMore after the 8th release.
REQ-041 rd_data=24'hFFFFFF -> grey=765, r=g=b=8'hFF.
REQ-042 rd_data=24'h010203 -> grey=6.
REQ-043 wantData held high continuously -> exactly one newData per request; no second pulse until wantData drops.
REQ-044 wantData rises at cycle N in ARMED -> newData at N+3.
REQ-045 start pulsed during WAIT -> ignored; pixel count unchanged.
REQ-046 start pulsed in DONE -> noMore clears and the sequence repeats identically.

Source files
------------

// File: rtl/pixel_stream_feeder_pkg.sv
// Shared types for the pixel feeder: controller states, the {r,g,b} pixel
// layout as it arrives from the frame buffer, and the grey sum width.
package pixel_stream_feeder_pkg;

  localparam int GREY_W = 10;
  localparam int CHAN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT,
    ST_RELEASE,
    ST_DONE
  } feeder_state_t;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/subsample_counter.sv
// Column/row stride counters for subsampled frame traversal. The row counter
// is allowed to step past the frame so "last" marks an exhausted frame.
module subsample_counter #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int STEP    = 4,
  parameter int COL_W   = $clog2(FRAME_W + STEP + 1),
  parameter int ROW_W   = $clog2(FRAME_H + STEP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_sum;

  assign col_sum = col_reg + COL_W'(STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (clear) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (advance) begin
      // Wrap to the next sampled line once the stride leaves the line.
      if (col_sum >= COL_W'(FRAME_W)) begin
        col_reg <= '0;
        row_reg <= row_reg + ROW_W'(STEP);
      end else begin
        col_reg <= col_sum;
      end
    end
  end

  assign col  = col_reg;
  assign row  = row_reg;
  assign last = (row_reg >= ROW_W'(FRAME_H));

endmodule

// File: rtl/pixel_stream_feeder.sv
// Walks a frame buffer at a fixed stride and hands one pixel at a time to a
// consumer over a four-phase wantData/newData handshake.
module pixel_stream_feeder
  import pixel_stream_feeder_pkg::*;
#(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int STEP    = 4,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [23:0]       rd_data,
  input  logic              wantData,
  output logic              newData,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic [GREY_W-1:0] grey,
  output logic              noMore,
  output logic              busy
);

  localparam int COL_W = $clog2(FRAME_W + STEP + 1);
  localparam int ROW_W = $clog2(FRAME_H + STEP + 1);

  feeder_state_t     state_reg, state_next;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              last;
  logic              start_ok;
  logic              fetch_go;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] rd_addr_reg;
  pixel_t            rd_pix;
  pixel_t            pix_reg;
  logic [GREY_W-1:0] grey_next;
  logic [GREY_W-1:0] grey_reg;

  assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign fetch_go = (state_reg == ST_ARMED) && wantData;

  subsample_counter #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .STEP    (STEP),
    .COL_W   (COL_W),
    .ROW_W   (ROW_W)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .advance (state_reg == ST_PRESENT),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start_ok) state_next = ST_ARMED;
      ST_ARMED:   if (wantData) state_next = ST_FETCH;
      ST_FETCH:   state_next = ST_WAIT;
      ST_WAIT:    state_next = ST_PRESENT;
      ST_PRESENT: state_next = ST_RELEASE;
      ST_RELEASE: if (!wantData) state_next = last ? ST_DONE : ST_ARMED;
      ST_DONE:    if (start_ok) state_next = ST_ARMED;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Address is latched on entry to FETCH so it never shows the past-the-end row.
  assign addr_next = ADDR_W'(row) * ADDR_W'(FRAME_W) + ADDR_W'(col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_reg <= '0;
    end else if (fetch_go) begin
      rd_addr_reg <= addr_next;
    end
  end

  assign rd_pix    = rd_data;
  assign grey_next = GREY_W'(rd_pix.r) + GREY_W'(rd_pix.g) + GREY_W'(rd_pix.b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_reg  <= '0;
      grey_reg <= '0;
    end else if (state_reg == ST_WAIT) begin
      pix_reg  <= rd_pix;
      grey_reg <= grey_next;
    end
  end

  assign rd_addr = rd_addr_reg;
  assign rd_en   = (state_reg == ST_FETCH);
  assign newData = (state_reg == ST_PRESENT);
  assign noMore  = (state_reg == ST_DONE);
  assign busy    = !(state_reg == ST_IDLE || state_reg == ST_DONE);
  assign r       = pix_reg.r;
  assign g       = pix_reg.g;
  assign b       = pix_reg.b;
  assign grey    = grey_reg;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Randomised consumer driving the feeder over a small 8x4 frame; a monitor
// checks every read address and delivered pixel against a queued reference.
module tb_pixel_stream_feeder;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int STEP = 2;
  localparam int AW   = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [23:0]   rd_data = '0;
  logic          wantData = 1'b0;
  logic          newData;
  logic [7:0]    r, g, b;
  logic [9:0]    grey;
  logic          noMore;
  logic          busy;

  pixel_stream_feeder #(
    .FRAME_W (W),
    .FRAME_H (H),
    .STEP    (STEP),
    .ADDR_W  (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .wantData (wantData),
    .newData  (newData),
    .r        (r),
    .g        (g),
    .b        (b),
    .grey     (grey),
    .noMore   (noMore),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;
  bit expect_nd = 1'b0;
  bit prev_rd_en = 1'b0;
  int last_addr = 0;

  logic [23:0] mem [0:W*H-1];
  int          exp_addr_q[$];
  logic [23:0] exp_pix_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous frame buffer: data appears one cycle after rd_en, junk otherwise.
  always @(posedge clk) begin
    if (rd_en && rd_addr < AW'(W*H)) rd_data <= mem[rd_addr];
    else rd_data <= 24'($urandom);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Reference: visit every STEP-th pixel of every STEP-th line, raster order.
  task automatic push_frame(output int n);
    n = 0;
    for (int y = 0; y < H; y += STEP) begin
      for (int x = 0; x < W; x += STEP) begin
        exp_addr_q.push_back(y * W + x);
        exp_pix_q.push_back(mem[y * W + x]);
        n++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (rd_en) begin
        chk("rd_en_one_cycle", prev_rd_en, 0);
        if (exp_addr_q.size() == 0) begin
          fail("rd_en_unexpected", $sformatf("read of addr %0d with nothing outstanding", rd_addr));
        end else begin
          last_addr = exp_addr_q.pop_front();
          chk("rd_addr", rd_addr, last_addr);
        end
      end
      if (newData) begin
        if (!expect_nd) begin
          fail("newdata_spurious", $sformatf("pulse at cycle %0d without a pending request", cyc));
        end else if (exp_pix_q.size() == 0) begin
          expect_nd = 1'b0;
          fail("newdata_unexpected", "pixel delivered with none outstanding");
        end else begin
          logic [23:0] p;
          expect_nd = 1'b0;
          p = exp_pix_q.pop_front();
          chk("latency", cyc - rise_cyc, 3);
          chk("r", r, p[23:16]);
          chk("g", g, p[15:8]);
          chk("b", b, p[7:0]);
          chk("grey", grey, int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]));
          chk("busy_in_frame", busy, 1);
          $display("pixel addr=%0d rgb=%06h grey=%0d cycle=%0d", last_addr, {r, g, b}, grey, cyc);
        end
      end
      prev_rd_en = rd_en;
    end else begin
      prev_rd_en = 1'b0;
    end
  end

  // One four-phase request; optionally pulses start while the DUT sits in WAIT.
  task automatic request(input bit start_in_wait);
    int n;
    repeat ($urandom_range(1, 3)) step_clk();
    wantData  = 1'b1;
    rise_cyc  = cyc;
    expect_nd = 1'b1;
    if (start_in_wait) begin
      repeat (2) step_clk();
      start = 1'b1;
      step_clk();
      start = 1'b0;
    end
    n = 0;
    while (expect_nd && n < 20) begin
      step_clk();
      n++;
    end
    if (expect_nd) begin
      fail("newdata_timeout", $sformatf("no pixel 20 cycles after request at cycle %0d", rise_cyc));
      expect_nd = 1'b0;
    end
    repeat ($urandom_range(0, 4)) step_clk();
    wantData = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_clk();
    start = 1'b0;
    chk("nomore_after_start", noMore, 0);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input int wait_idx);
    int npix;
    push_frame(npix);
    pulse_start();
    for (int k = 0; k < npix; k++) begin
      request(k == wait_idx);
      if (k == npix - 2) begin
        repeat (2) step_clk();
        chk("nomore_before_last", noMore, 0);
      end
    end
    repeat (2) step_clk();
    chk("nomore_at_end", noMore, 1);
    chk("busy_at_end", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int npix;
    for (int i = 0; i < W * H; i++) mem[i] = 24'($urandom);
    mem[0] = 24'hFFFFFF;
    mem[2] = 24'h010203;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_newData", newData, 0);
    chk("reset_noMore", noMore, 0);
    chk("reset_busy", busy, 0);
    chk("reset_grey", grey, 0);
    chk("reset_rgb", {r, g, b}, 0);
    step_clk();
    reset = 1'b1;
    repeat (4) step_clk();
    chk("idle_busy", busy, 0);
    chk("idle_noMore", noMore, 0);

    run_frame($urandom_range(0, 7));

    // Requests while the frame is exhausted must not produce pixels.
    wantData = 1'b1;
    repeat (6) step_clk();
    wantData = 1'b0;
    step_clk();
    chk("done_nomore_held", noMore, 1);

    run_frame($urandom_range(0, 7));

    // Async reset while PRESENT, then a fresh frame from address 0.
    push_frame(npix);
    pulse_start();
    for (int k = 0; k < 3; k++) request(1'b0);
    repeat ($urandom_range(1, 3)) step_clk();
    wantData  = 1'b1;
    rise_cyc  = cyc;
    expect_nd = 1'b1;
    repeat (3) step_clk();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_rd_en", rd_en, 0);
    chk("midreset_rd_addr", rd_addr, 0);
    chk("midreset_newData", newData, 0);
    chk("midreset_noMore", noMore, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_grey", grey, 0);
    chk("midreset_rgb", {r, g, b}, 0);
    wantData  = 1'b0;
    expect_nd = 1'b0;
    exp_addr_q.delete();
    exp_pix_q.delete();
    step_clk();
    reset = 1'b1;
    repeat (5) step_clk();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_noMore", noMore, 0);

    run_frame(-1);

    chk("addr_queue_drained", exp_addr_q.size(), 0);
    chk("pix_queue_drained", exp_pix_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
